// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, majority-voted bit sampling,
// and a first-word-fall-through receive FIFO with a valid/ready pop side.
module uart_rx #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        CLK100MHZ,
  input  logic                        rst_n,
  input  logic                        uart_txd_in,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        frame_err,
  output logic                        overrun,
  input  logic                        overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0] rx_count
);

  localparam int CPB   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(CPB);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic sync_p0, s, s_prev, s_d2;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0] idx, idx_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic push_req, ferr_nxt, bit_s;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic full, pop, push_ok, ovr_set;

  // Synchronizer plus two history taps feeding the 3-sample vote
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      s       <= 1'b1;
      s_prev  <= 1'b1;
      s_d2    <= 1'b1;
    end else begin
      sync_p0 <= uart_txd_in;
      s       <= sync_p0;
      s_prev  <= s;
      s_d2    <= s_prev;
    end
  end

  assign bit_s = maj3(s_d2, s_prev, s);

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    shreg <= shreg_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    push_req  = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (s_prev && !s) state_nxt = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          state_nxt = s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {bit_s, shreg[7:1]};
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt = idx + 3'd1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (bit_s) begin
            push_req  = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must not be decoded as a stream of zeros
        if (s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_count = wr_ptr - rd_ptr;
  assign rx_valid = (rx_count != '0);
  assign full     = (rx_count == PTR_W'(FIFO_DEPTH));
  assign pop      = rx_valid && rx_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO is still taken
  assign push_ok  = push_req && (!full || pop);
  assign ovr_set  = push_req && full && !pop;
  assign rx_data  = rx_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  always_ff @(posedge CLK100MHZ) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (ovr_set)          overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule
